// File: rtl/serdes_tx_arbiter.sv
// Four-requester round-robin burst arbiter feeding a SerDes parallel input.
// A grant holds for one burst; words are registered onto ParDataOut on accept.
module serdes_tx_arbiter #(
    parameter int DWid     = 32,
    parameter int MaxBurst = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [3:0]        ReqIn,
    input  logic [3:0]        LastIn,
    input  logic [4*DWid-1:0] DataIn,
    input  logic              TxFull,
    output logic [3:0]        GntOut,
    output logic [3:0]        AckOut,
    output logic [DWid-1:0]   ParDataOut,
    output logic              ParValidOut,
    output logic [1:0]        SrcIdOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [7:0] MaxCnt = 8'(MaxBurst);

    state_t          state_q, state_d;
    logic [3:0]      gnt_q, gnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [7:0]      bcnt_q, bcnt_d;
    logic [DWid-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic [1:0]      src_q, src_d;

    logic [1:0]      win;
    logic            win_found;
    logic [1:0]      cand;
    logic            accept;
    logic            withdrawn;
    logic            burst_end;
    logic [7:0]      bcnt_inc;
    logic [DWid-1:0] word_g;

    // Round-robin search: first requester at or after the pointer, wrapping.
    always_comb begin
        win       = ptr_q;
        win_found = 1'b0;
        cand      = ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + i[1:0];
            if (!win_found && ReqIn[cand]) begin
                win       = cand;
                win_found = 1'b1;
            end
        end
    end

    // Granted requester's word, accept strobe and burst termination.
    always_comb begin
        word_g    = DataIn[idx_q*DWid +: DWid];
        AckOut    = gnt_q & ReqIn & {4{~TxFull}};
        accept    = |AckOut;
        bcnt_inc  = bcnt_q + 8'd1;
        withdrawn = (state_q == XFER) && !ReqIn[idx_q];
        burst_end = withdrawn
                  || (accept && (LastIn[idx_q] || (bcnt_inc == MaxCnt)));
    end

    // Next-state and datapath update; ParValidOut pulses only after an accept.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        bcnt_d  = bcnt_q;
        data_d  = data_q;
        src_d   = src_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_found) begin
                    idx_d   = win;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                gnt_d   = 4'b0001 << idx_q;
                bcnt_d  = 8'd0;
                state_d = XFER;
            end
            XFER: begin
                if (accept) begin
                    data_d  = word_g;
                    src_d   = idx_q;
                    valid_d = 1'b1;
                    bcnt_d  = bcnt_inc;
                end
                if (burst_end) begin
                    gnt_d   = 4'b0000;
                    ptr_d   = idx_q + 2'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            idx_q   <= 2'd0;
            ptr_q   <= 2'd0;
            bcnt_q  <= 8'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    assign GntOut      = gnt_q;
    assign ParDataOut  = data_q;
    assign ParValidOut = valid_q;
    assign SrcIdOut    = src_q;

endmodule
